// File: rtl/result_status_emitter_if.sv
// Signal bundle between the firing FSM / output FIFOs and result_status_emitter.
// slave is the emitter side, master is the driving environment.
interface result_status_emitter_if #(
    parameter int word_size = 16
);
    logic                   en_wr_output_fifo;
    logic [2*word_size-1:0] result;
    logic [2*word_size-1:0] status;
    logic [word_size-1:0]   pop_out_fifo_result;
    logic [word_size-1:0]   pop_out_fifo_status;
    logic                   wr_out_result;
    logic                   wr_out_status;
    logic [word_size-1:0]   data_out_result;
    logic [word_size-1:0]   data_out_status;
    logic                   busy;
    logic                   done_emit;
    logic [7:0]             drop_count;

    modport slave (
        input  en_wr_output_fifo, result, status,
        input  pop_out_fifo_result, pop_out_fifo_status,
        output wr_out_result, wr_out_status,
        output data_out_result, data_out_status,
        output busy, done_emit, drop_count
    );

    modport master (
        output en_wr_output_fifo, result, status,
        output pop_out_fifo_result, pop_out_fifo_status,
        input  wr_out_result, wr_out_status,
        input  data_out_result, data_out_status,
        input  busy, done_emit, drop_count
    );
endinterface

// File: rtl/result_status_emitter.sv
// Captures a result/status pair and writes it as two tokens into two FIFOs.
// Optional EMITTER_DROP_COUNT_EN: count strobes dropped while busy.
module result_status_emitter #(
    parameter int word_size   = 16,
    parameter int buffer_size = 1024
) (
    input logic clk,
    input logic rst,
    result_status_emitter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_SPACE,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    localparam logic [word_size-1:0] LIMIT = word_size'(buffer_size - 2);

    state_t                 state;
    state_t                 nxt;
    logic [2*word_size-1:0] res_q;
    logic [2*word_size-1:0] sts_q;
    logic                   wr;
    logic                   busy;
    logic                   done;
    logic [word_size-1:0]   d_res;
    logic [word_size-1:0]   d_sts;
    logic                   room;
    logic                   accept;

    assign room = (bus.pop_out_fifo_result <= LIMIT)
               && (bus.pop_out_fifo_status <= LIMIT);
    assign accept = (state == IDLE) && bus.en_wr_output_fifo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            res_q <= '0;
            sts_q <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                res_q <= bus.result;
                sts_q <= bus.status;
            end
        end
    end

    always_comb begin
        nxt   = state;
        wr    = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        d_res = '0;
        d_sts = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.en_wr_output_fifo) nxt = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                if (room) nxt = WR_LO;
            end
            WR_LO: begin
                wr    = 1'b1;
                d_res = res_q[word_size-1:0];
                d_sts = sts_q[word_size-1:0];
                nxt   = WR_HI;
            end
            WR_HI: begin
                wr    = 1'b1;
                d_res = res_q[2*word_size-1:word_size];
                d_sts = sts_q[2*word_size-1:word_size];
                nxt   = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign bus.wr_out_result   = wr;
    assign bus.wr_out_status   = wr;
    assign bus.data_out_result = d_res;
    assign bus.data_out_status = d_sts;
    assign bus.busy            = busy;
    assign bus.done_emit       = done;

`ifdef EMITTER_DROP_COUNT_EN
    logic [7:0] drop_q;

    // Saturates so a stuck strobe cannot wrap the count back to small values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 8'h00;
        end else if (bus.en_wr_output_fifo && (state != IDLE)
                     && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'h01;
        end
    end

    assign bus.drop_count = drop_q;
`else
    assign bus.drop_count = 8'h00;
`endif
endmodule

// File: tb/tb_result_status_emitter.sv
// Self-checking bench for result_status_emitter: vector table, scoreboard
// of expected FIFO tokens, and hand sequences for multi-cycle corners.
module tb_result_status_emitter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    result_status_emitter_if #(.word_size(16)) bus ();

    result_status_emitter #(
        .word_size(16),
        .buffer_size(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] status;
        logic [15:0] res_lo;
        logic [15:0] sts_lo;
        logic [15:0] res_hi;
        logic [15:0] sts_hi;
    } vec_t;

    vec_t vecs[5];

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_drop = 0;
    logic [31:0] sb[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Token scoreboard: {result token, status token} per write cycle
    always @(negedge clk) begin
        if (rst) begin
            if (bus.wr_out_result || bus.wr_out_status) begin
                check("wr_both", {30'b0, bus.wr_out_result, bus.wr_out_status},
                      32'h3);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write actual=%h expected=none",
                             {bus.data_out_result, bus.data_out_status});
                end else begin
                    check("token", {bus.data_out_result, bus.data_out_status},
                          sb.pop_front());
                end
            end else begin
                check("idle_data", {bus.data_out_result, bus.data_out_status},
                      32'h0);
            end
        end
    end

    task automatic push_pair(input logic [31:0] r, input logic [31:0] s);
        sb.push_back({r[15:0], s[15:0]});
        sb.push_back({r[31:16], s[31:16]});
    endtask

    task automatic strobe(input logic [31:0] r, input logic [31:0] s);
        @(negedge clk);
        bus.en_wr_output_fifo = 1'b1;
        bus.result = r;
        bus.status = s;
        @(negedge clk);
        bus.en_wr_output_fifo = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.done_emit) begin
                cyc = i;
                break;
            end
        end
        if (cyc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout actual=none expected=done_emit");
        end
    endtask

    task automatic drop_inc();
`ifdef EMITTER_DROP_COUNT_EN
        if (exp_drop < 255) exp_drop++;
`endif
    endtask

    initial begin
        int cyc;

        vecs[0] = '{32'hDEAD_BEEF, 32'h0000_0001,
                    16'hBEEF, 16'h0001, 16'hDEAD, 16'h0000};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000,
                    16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF,
                    16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[3] = '{32'h1234_5678, 32'h8765_4321,
                    16'h5678, 16'h4321, 16'h1234, 16'h8765};
        vecs[4] = '{32'h8000_0001, 32'h0001_8000,
                    16'h0001, 16'h8000, 16'h8000, 16'h0001};

        bus.en_wr_output_fifo   = 1'b0;
        bus.result              = '0;
        bus.status              = '0;
        bus.pop_out_fifo_result = '0;
        bus.pop_out_fifo_status = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done_emit}, 32'h0);
        check("rst_wr", {30'b0, bus.wr_out_result, bus.wr_out_status}, 32'h0);
        check("rst_data", {bus.data_out_result, bus.data_out_status}, 32'h0);
        check("rst_drop", {24'b0, bus.drop_count}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            sb.push_back({vecs[i].res_lo, vecs[i].sts_lo});
            sb.push_back({vecs[i].res_hi, vecs[i].sts_hi});
            strobe(vecs[i].result, vecs[i].status);
            check("busy_after_strobe", {31'b0, bus.busy}, 32'h1);
            wait_done(10, cyc);
            check("latency", cyc, 32'd3);
            @(negedge clk);
            check("idle_after_done", {30'b0, bus.busy, bus.done_emit}, 32'h0);
        end

        // Strobe in WR_LO must not disturb the pair in flight
        push_pair(32'hCAFE_F00D, 32'h0BAD_0002);
        strobe(32'hCAFE_F00D, 32'h0BAD_0002);
        @(negedge clk);
        check("wr_lo", {31'b0, bus.wr_out_result}, 32'h1);
        bus.en_wr_output_fifo = 1'b1;
        bus.result = 32'h1234_5678;
        bus.status = 32'h5555_AAAA;
        @(negedge clk);
        bus.en_wr_output_fifo = 1'b0;
        drop_inc();
        wait_done(5, cyc);
        check("busy_drop_lat", cyc, 32'd1);
        check("drop_wr_lo", {24'b0, bus.drop_count}, exp_drop);

        // Strobe in the DONE cycle is dropped too
        push_pair(32'hA5A5_5A5A, 32'h0000_0003);
        strobe(32'hA5A5_5A5A, 32'h0000_0003);
        wait_done(10, cyc);
        bus.en_wr_output_fifo = 1'b1;
        bus.result = 32'h7777_7777;
        @(negedge clk);
        bus.en_wr_output_fifo = 1'b0;
        drop_inc();
        check("done_drop_busy", {31'b0, bus.busy}, 32'h0);
        @(negedge clk);
        check("done_drop_idle", {30'b0, bus.busy, bus.wr_out_result}, 32'h0);
        check("drop_done", {24'b0, bus.drop_count}, exp_drop);

        // Result FIFO back-pressure
        bus.pop_out_fifo_result = 16'd1023;
        push_pair(32'h0F0F_1E1E, 32'h0000_0004);
        strobe(32'h0F0F_1E1E, 32'h0000_0004);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold",
                  {29'b0, bus.wr_out_result, bus.wr_out_status, bus.busy},
                  32'h1);
        end
        bus.pop_out_fifo_result = 16'd1022;
        @(negedge clk);
        check("bp_release", {31'b0, bus.wr_out_result}, 32'h1);
        wait_done(5, cyc);
        check("bp_lat", cyc, 32'd2);
        bus.pop_out_fifo_result = 16'd0;

        // Status FIFO full only
        bus.pop_out_fifo_status = 16'd1024;
        push_pair(32'h2222_3333, 32'h4444_5555);
        strobe(32'h2222_3333, 32'h4444_5555);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("sts_hold",
                  {30'b0, bus.wr_out_result, bus.wr_out_status}, 32'h0);
        end
        bus.pop_out_fifo_status = 16'd1023;
        @(negedge clk);
        check("sts_1023", {31'b0, bus.wr_out_status}, 32'h0);
        bus.pop_out_fifo_status = 16'd1022;
        @(negedge clk);
        check("sts_release", {31'b0, bus.wr_out_status}, 32'h1);
        wait_done(5, cyc);
        check("sts_lat", cyc, 32'd2);
        bus.pop_out_fifo_status = 16'd0;

`ifdef EMITTER_DROP_COUNT_EN
        bus.pop_out_fifo_result = 16'd1023;
        push_pair(32'h9999_8888, 32'h0000_0005);
        @(negedge clk);
        bus.en_wr_output_fifo = 1'b1;
        bus.result = 32'h9999_8888;
        bus.status = 32'h0000_0005;
        repeat (301) @(negedge clk);
        bus.en_wr_output_fifo = 1'b0;
        for (int i = 0; i < 300; i++) drop_inc();
        check("drop_sat", {24'b0, bus.drop_count}, exp_drop);
        bus.pop_out_fifo_result = 16'd0;
        wait_done(6, cyc);
        check("sat_lat", cyc, 32'd3);
`endif

        // Reset during WR_HI
        push_pair(32'hBBBB_AAAA, 32'hDDDD_CCCC);
        strobe(32'hBBBB_AAAA, 32'hDDDD_CCCC);
        @(negedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_hi", {31'b0, bus.wr_out_result}, 32'h1);
        rst = 1'b0;
        #1;
        check("mid_rst_wr", {30'b0, bus.wr_out_result, bus.wr_out_status},
              32'h0);
        check("mid_rst_data", {bus.data_out_result, bus.data_out_status},
              32'h0);
        check("mid_rst_busy", {30'b0, bus.busy, bus.done_emit}, 32'h0);
        check("mid_rst_drop", {24'b0, bus.drop_count}, 32'h0);
        exp_drop = 0;
        check("mid_rst_sb", sb.size(), 32'd1);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", {30'b0, bus.busy, bus.done_emit}, 32'h0);
        end
        sb.push_back({vecs[3].res_lo, vecs[3].sts_lo});
        sb.push_back({vecs[3].res_hi, vecs[3].sts_hi});
        strobe(vecs[3].result, vecs[3].status);
        wait_done(10, cyc);
        check("post_rst_lat", cyc, 32'd3);

        @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
